// File: rtl/modadder_arbiter.sv
// Round-robin arbiter sharing one modadder among NREQ requesters, with a hang watchdog.
// One operation in flight; response pulses adder latency + 2 cycles after the handshake.
module modadder_arbiter #(
  parameter int NREQ    = 2,
  parameter int WIDTH   = 381,
  parameter int TIMEOUT = 1023
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_sub,
  input  logic [WIDTH-1:0]      in_m,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [NREQ-1:0]       rsp_err,
  output logic [WIDTH-1:0]      rsp_result,
  output logic                  busy,
  output logic                  ma_start,
  output logic [WIDTH-1:0]      ma_a,
  output logic [WIDTH-1:0]      ma_b,
  output logic [WIDTH-1:0]      ma_m,
  output logic                  ma_sub,
  input  logic                  ma_done,
  input  logic [WIDTH-1:0]      ma_result
);
  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNTW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_ABORT} state_t;

  state_t            state, state_nxt;
  logic [IDXW-1:0]   last_grant;
  logic [IDXW-1:0]   gidx;
  logic [IDXW-1:0]   grant_idx;
  logic [IDXW-1:0]   cand;
  logic              grant_vld;
  logic [CNTW-1:0]   wd_cnt;
  logic [WIDTH-1:0]  a_arr [NREQ];
  logic [WIDTH-1:0]  b_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*WIDTH +: WIDTH];
    assign b_arr[i] = req_b[i*WIDTH +: WIDTH];
  end

  assign ma_m = in_m;

  // Scan from farthest to nearest so the nearest valid index after last_grant wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IDXW'((int'(last_grant) + k) % NREQ);
      if (req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = '0;
    rsp_err   = '0;
    ma_start  = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (grant_vld) begin
          req_ready[grant_idx] = 1'b1;
          state_nxt            = S_ISSUE;
        end
      end
      S_ISSUE: begin
        ma_start  = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // A done arriving in the last watchdog cycle still completes normally.
        if (ma_done)                      state_nxt = S_RESP;
        else if (wd_cnt == CNTW'(TIMEOUT)) state_nxt = S_ABORT;
      end
      S_RESP: begin
        rsp_valid[gidx] = 1'b1;
        state_nxt       = S_IDLE;
      end
      S_ABORT: begin
        rsp_err[gidx] = 1'b1;
        state_nxt     = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ma_a       <= '0;
      ma_b       <= '0;
      ma_sub     <= 1'b0;
      gidx       <= '0;
      last_grant <= IDXW'(NREQ - 1);
      wd_cnt     <= '0;
      rsp_result <= '0;
    end else begin
      if (state == S_IDLE && grant_vld) begin
        ma_a       <= a_arr[grant_idx];
        ma_b       <= b_arr[grant_idx];
        ma_sub     <= req_sub[grant_idx];
        gidx       <= grant_idx;
        last_grant <= grant_idx;
      end
      if (state == S_ISSUE)     wd_cnt <= '0;
      else if (state == S_WAIT) wd_cnt <= wd_cnt + CNTW'(1);
      if (state == S_WAIT && ma_done) rsp_result <= ma_result;
    end
  end
endmodule

// File: tb/tb_modadder_arbiter.sv
// Bench for modadder_arbiter: vector table, arbitration/timeout/reset sequences, and a
// randomized run against a transaction-level model with a stand-in modadder.
module tb_modadder_arbiter;
  localparam int NREQ = 3, WIDTH = 16, TIMEOUT = 20;

  logic                  clk = 1'b0;
  logic                  resetn = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a = '0;
  logic [NREQ*WIDTH-1:0] req_b = '0;
  logic [NREQ-1:0]       req_sub = '0;
  logic [WIDTH-1:0]      in_m = 16'd13;
  logic [NREQ-1:0]       rsp_valid, rsp_err;
  logic [WIDTH-1:0]      rsp_result, ma_a, ma_b, ma_m;
  logic                  busy, ma_start, ma_sub;
  logic                  ma_done = 1'b0;
  logic [WIDTH-1:0]      ma_result = '0;

  modadder_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub), .in_m(in_m),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_result(rsp_result), .busy(busy),
    .ma_start(ma_start), .ma_a(ma_a), .ma_b(ma_b), .ma_m(ma_m), .ma_sub(ma_sub),
    .ma_done(ma_done), .ma_result(ma_result)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int lat = 1, pend = 0;
  bit hang = 1'b0, spur = 1'b0;

  typedef struct { int idx; int a; int b; bit sub; int lat; int res; bit spur; } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [NREQ-1:0] oh(input int i);
    return NREQ'(1) << i;
  endfunction

  function automatic logic [WIDTH-1:0] modop(input int a, input int b, input int m, input bit sub);
    int r;
    if (sub) r = (a >= b) ? a - b : a + m - b;
    else     r = (a + b >= m) ? a + b - m : a + b;
    return WIDTH'(r);
  endfunction

  task automatic set_req(input int i, input int a, input int b, input bit sub);
    req_a[i*WIDTH +: WIDTH] = WIDTH'(a);
    req_b[i*WIDTH +: WIDTH] = WIDTH'(b);
    req_sub[i]              = sub;
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ma_start"}, ma_start, 0);
    chk({tag, "_ma_a"}, ma_a, 0);
    chk({tag, "_ma_b"}, ma_b, 0);
    chk({tag, "_ma_sub"}, ma_sub, 0);
    chk({tag, "_rsp_result"}, rsp_result, 0);
  endtask

  // Single request from idle; checks issue, latency, response pulse and return to idle.
  task automatic do_op(input int idx, input int a, input int b, input bit sub, input int l,
                       input int res, input bit spur_issue);
    int n;
    lat = l;
    set_req(idx, a, b, sub);
    req_valid = oh(idx);
    if (spur_issue) spur = 1'b1;
    #1;
    chk("grant", req_ready, oh(idx));
    step();
    req_valid = '0;
    #1;
    chk("ma_start", ma_start, 1);
    chk("ma_a", ma_a, a);
    chk("ma_b", ma_b, b);
    chk("ma_sub", ma_sub, sub);
    chk("busy", busy, 1);
    n = 1;
    do begin step(); n++; #1; end while (rsp_valid == '0 && n < 60);
    chk("rsp_latency", n, l + 2);
    chk("rsp_valid", rsp_valid, oh(idx));
    chk("rsp_result", rsp_result, res);
    chk("rsp_err_quiet", rsp_err, 0);
    step(); #1;
    chk("rsp_pulse", rsp_valid, 0);
    chk("busy_idle", busy, 0);
  endtask

  // Stand-in modadder: done after 'lat' cycles from start; 'spur' injects a stray done.
  initial begin
    forever begin
      @(posedge clk); #1;
      ma_done = 1'b0;
      if (spur) begin
        ma_done   = 1'b1;
        ma_result = 16'hBEEF;
        spur      = 1'b0;
      end
      if (!resetn) pend = 0;
      else if (pend > 0) begin
        pend--;
        if (pend == 0 && !hang) begin
          ma_done   = 1'b1;
          ma_result = modop(int'(ma_a), int'(ma_b), int'(ma_m), ma_sub);
        end
      end
      if (ma_start && resetn) pend = lat;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  logic [NREQ-1:0]  v, exp_rdy;
  int               ra[NREQ], rb[NREQ];
  bit               rs[NREQ];
  int               g, c, m_last, due, e_idx, hs_g, n;
  bit               inflight, rsp_now;
  logic [WIDTH-1:0] e_res;

  initial begin
    tbl[0] = '{0,  7,  9, 1'b0, 1,  3, 1'b0};
    tbl[1] = '{1,  3,  9, 1'b1, 2,  7, 1'b1};
    tbl[2] = '{2, 12, 12, 1'b0, 3, 11, 1'b0};
    tbl[3] = '{1,  0,  0, 1'b0, 1,  0, 1'b0};
    tbl[4] = '{0, 12,  1, 1'b0, 4,  0, 1'b1};
    tbl[5] = '{2,  0,  1, 1'b1, 1, 12, 1'b0};
    tbl[6] = '{0, 12,  0, 1'b1, 2, 12, 1'b0};

    repeat (3) step();
    #1;
    chk_zero_outs("reset");
    resetn = 1'b1;
    step(); #1;
    chk("ma_m_pass", ma_m, 13);

    for (int i = 0; i < 7; i++)
      do_op(tbl[i].idx, tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].lat, tbl[i].res, tbl[i].spur);

    // Stray done while idle must not respond or overwrite the held result.
    spur = 1'b1;
    step(); #1;
    chk("idle_spur_rsp", rsp_valid, 0);
    step(); #1;
    chk("idle_spur_rsp2", rsp_valid, 0);
    chk("idle_spur_result", rsp_result, 12);

    // Two requesters held valid: grants alternate 0,1,0,1 starting at 0 after reset.
    resetn = 1'b0; step(); resetn = 1'b1; step();
    set_req(0, 7, 9, 1'b0);
    set_req(1, 3, 9, 1'b1);
    lat = 1;
    req_valid = 3'b011;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      #1;
      while (req_ready == '0 && n < 10) begin step(); #1; n++; end
      chk("rr_grant", req_ready, oh(k % 2));
      step();
      n = 0;
      #1;
      while (rsp_valid == '0 && n < 20) begin
        chk("rr_no_grant_busy", req_ready, 0);
        step(); #1; n++;
      end
      chk("rr_rsp", rsp_valid, oh(k % 2));
      chk("rr_result", rsp_result, (k % 2 == 0) ? 3 : 7);
      step(); #1;
      chk("rr_pulse", rsp_valid, 0);
    end
    req_valid = '0;
    step();

    // Hung adder: abort exactly TIMEOUT+2 cycles after ma_start.
    hang = 1'b1;
    lat = 2;
    set_req(2, 5, 4, 1'b0);
    req_valid = oh(2);
    #1;
    chk("to_grant", req_ready, oh(2));
    step();
    req_valid = '0;
    #1;
    chk("to_start", ma_start, 1);
    n = 0;
    do begin step(); n++; #1; end while (rsp_err == '0 && n < TIMEOUT + 40);
    chk("to_cycles", n, TIMEOUT + 2);
    chk("to_err", rsp_err, oh(2));
    chk("to_no_valid", rsp_valid, 0);
    chk("to_result_held", rsp_result, 7);
    step(); #1;
    chk("to_err_pulse", rsp_err, 0);
    chk("to_idle", busy, 0);
    hang = 1'b0;

    // Reset while waiting on the adder drops the operation entirely.
    lat = 6;
    set_req(0, 4, 4, 1'b0);
    req_valid = oh(0);
    step();
    req_valid = '0;
    step(); step();
    #1;
    chk("mid_wait_busy", busy, 1);
    resetn = 1'b0;
    #1;
    chk_zero_outs("mid_reset");
    step();
    resetn = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step(); #1;
      chk("post_reset_quiet", {rsp_valid, rsp_err}, 0);
    end
    do_op(0, 7, 9, 1'b0, 1, 3, 1'b0);

    // Randomized traffic against a transaction-level model.
    resetn = 1'b0; step(); resetn = 1'b1;
    in_m = 16'd1000;
    step();
    v = '0; m_last = NREQ - 1; inflight = 1'b0; due = 0; e_idx = 0; hs_g = -1; e_res = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (hs_g >= 0) begin
        if ($urandom_range(1, 0) == 0) v[hs_g] = 1'b0;
        hs_g = -1;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!v[i] && $urandom_range(3, 0) == 0) begin
          ra[i] = $urandom_range(999, 0);
          rb[i] = $urandom_range(999, 0);
          rs[i] = 1'($urandom_range(1, 0));
          set_req(i, ra[i], rb[i], rs[i]);
          v[i] = 1'b1;
        end else if (v[i] && $urandom_range(15, 0) == 0) begin
          v[i] = 1'b0;
        end
      end
      req_valid = v;
      #1;
      g = -1;
      if (!inflight)
        for (int k = 1; k <= NREQ; k++) begin
          c = (m_last + k) % NREQ;
          if (g < 0 && v[c]) g = c;
        end
      exp_rdy = (g >= 0) ? oh(g) : NREQ'(0);
      rsp_now = inflight && (cyc == due);
      chk("rand_ready", req_ready, exp_rdy);
      chk("rand_busy", busy, inflight);
      chk("rand_rsp", rsp_valid, rsp_now ? oh(e_idx) : NREQ'(0));
      if (rsp_now) chk("rand_result", rsp_result, e_res);
      if (rsp_now) inflight = 1'b0;
      else if (g >= 0) begin
        inflight = 1'b1;
        e_idx    = g;
        m_last   = g;
        lat      = $urandom_range(6, 1);
        due      = cyc + 2 + lat;
        e_res    = modop(ra[g], rb[g], 1000, rs[g]);
        hs_g     = g;
      end
      step();
    end
    req_valid = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
